// File: rtl/lsu_trigger_chain.sv
// lsu_trigger_chain
// Debug trigger matcher for DC3 loads/stores with NAPOT masking, per-trigger
// hit thresholds, sequential chaining and sticky status. The fire pulse is
// registered into DC4.
// Optional feature: define LSU_TRIG_LOAD_DATA_EN to allow data-compare
// triggers (select=1) to match load data taken from lsu_result_dc3.
//
// Access qualification: lsu_valid_dc3 marks a live DC3 access for exactly the
// cycle it is high. There is no backpressure. An access that is killed or comes
// from DMA is ignored entirely.
//
// Arm state per trigger is visible on trig_armed. S_INIT is the "recompute
// after reset / config write" state. In S_INIT the trigger is armed when it is
// enabled and not chained. This lets reset take effect on trig_armed
// asynchronously without a data-dependent reset value.
module lsu_trigger_chain #(
  parameter int NUM_TRIG = 4,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_TRIG-1:0]          trig_en,
  input  logic [NUM_TRIG-1:0]          trig_select,
  input  logic [NUM_TRIG-1:0]          trig_load,
  input  logic [NUM_TRIG-1:0]          trig_store,
  input  logic [NUM_TRIG-1:0]          trig_napot,
  input  logic [NUM_TRIG-1:0]          trig_chain,
  input  logic [NUM_TRIG*DATA_W-1:0]   trig_tdata2,
  input  logic [NUM_TRIG*CNT_W-1:0]    trig_thresh,
  input  logic [NUM_TRIG-1:0]          trig_cfg_wr,
  input  logic [NUM_TRIG-1:0]          trig_status_clr,
  input  logic                         lsu_valid_dc3,
  input  logic                         lsu_dma_dc3,
  input  logic                         lsu_kill_dc3,
  input  logic                         lsu_load_dc3,
  input  logic                         lsu_store_dc3,
  input  logic [1:0]                   lsu_size_dc3,
  input  logic [DATA_W-1:0]            lsu_addr_dc3,
  input  logic [DATA_W-1:0]            store_data_dc3,
  input  logic [DATA_W-1:0]            lsu_result_dc3,
  output logic [NUM_TRIG-1:0]          lsu_trigger_match_dc4,
  output logic [NUM_TRIG-1:0]          trig_status,
  output logic [NUM_TRIG-1:0]          trig_armed
);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_DISARMED = 2'd1,
    S_ARMED    = 2'd2
  } trig_state_e;

  trig_state_e         state_q [NUM_TRIG];
  trig_state_e         state_d [NUM_TRIG];
  logic [CNT_W-1:0]    cnt_q   [NUM_TRIG];
  logic [CNT_W-1:0]    cnt_d   [NUM_TRIG];

  logic [NUM_TRIG-1:0] hit;
  logic [NUM_TRIG-1:0] fire;
  logic [NUM_TRIG-1:0] arm_eff;
  logic [NUM_TRIG-1:0] chain_up;
  logic [NUM_TRIG-1:0] fire_up;
  logic [NUM_TRIG:0]   chain_ext;
  logic [NUM_TRIG:0]   fire_ext;
  logic [NUM_TRIG-1:0] match_q;
  logic [NUM_TRIG-1:0] status_q;
  logic [DATA_W-1:0]   store_data_m;
  logic                acc_ok;

  // Keep only the bytes the access actually writes or reads.
  function automatic logic [DATA_W-1:0] size_mask(input logic [DATA_W-1:0] d,
                                                   input logic [1:0]        sz);
    logic [DATA_W-1:0] m;
    case (sz)
      2'd0:    m = DATA_W'(8'hFF);
      2'd1:    m = DATA_W'(16'hFFFF);
      default: m = '1;
    endcase
    return d & m;
  endfunction

  // Bit i of these vectors is the upstream (i-1) chain bit and fire.
  // Trigger 0 has no upstream.
  assign chain_ext = {trig_chain, 1'b0};
  assign fire_ext  = {fire, 1'b0};
  assign chain_up  = chain_ext[NUM_TRIG-1:0];
  assign fire_up   = fire_ext[NUM_TRIG-1:0];

  assign acc_ok       = lsu_valid_dc3 & ~lsu_dma_dc3 & ~lsu_kill_dc3;
  assign store_data_m = size_mask(store_data_dc3, lsu_size_dc3);

`ifdef LSU_TRIG_LOAD_DATA_EN
  logic [DATA_W-1:0] load_data_m;
  logic              unused_bits;
  assign load_data_m = size_mask(lsu_result_dc3, lsu_size_dc3);
  assign unused_bits = chain_ext[NUM_TRIG] ^ fire_ext[NUM_TRIG];
`else
  logic              unused_bits;
  assign unused_bits = (^lsu_result_dc3) ^ chain_ext[NUM_TRIG] ^ fire_ext[NUM_TRIG];
`endif

  // Per-trigger compare: pick the operand, apply the NAPOT mask, then qualify with access type.
  always_comb begin : cmp_p
    logic [DATA_W-1:0] t;
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] ign;
    logic              sel_st;
    logic              sel_ld;
    logic              eq;
    t      = '0;
    v      = '0;
    ign    = '0;
    sel_st = 1'b0;
    sel_ld = 1'b0;
    eq     = 1'b0;
    hit    = '0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      t      = trig_tdata2[i*DATA_W +: DATA_W];
      // A bit is ignored when every lower bit of tdata2 is one. Bit 0 is always ignored.
      ign    = '0;
      ign[0] = 1'b1;
      for (int k = 1; k < DATA_W; k++) begin
        ign[k] = ign[k-1] & t[k-1];
      end
      sel_st = lsu_store_dc3 & trig_store[i];
`ifdef LSU_TRIG_LOAD_DATA_EN
      sel_ld = lsu_load_dc3 & trig_load[i];
      if (!trig_select[i])    v = lsu_addr_dc3;
      else if (lsu_store_dc3) v = store_data_m;
      else                    v = load_data_m;
`else
      sel_ld = lsu_load_dc3 & trig_load[i] & ~trig_select[i];
      v      = trig_select[i] ? store_data_m : lsu_addr_dc3;
`endif
      eq     = trig_napot[i] ? (((v ^ t) & ~ign) == '0) : (v == t);
      hit[i] = acc_ok & (sel_st | sel_ld) & eq;
    end
  end

  // Effective arm state and fire decision. A config write in the same cycle drops the hit.
  always_comb begin : fire_p
    logic [CNT_W:0] cnt_inc;
    logic [CNT_W:0] thr_eff;
    logic [CNT_W-1:0] thr;
    cnt_inc = '0;
    thr_eff = '0;
    thr     = '0;
    arm_eff = '0;
    fire    = '0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      thr        = trig_thresh[i*CNT_W +: CNT_W];
      thr_eff    = (thr == '0) ? (CNT_W+1)'(1) : {1'b0, thr};
      cnt_inc    = {1'b0, cnt_q[i]} + (CNT_W+1)'(1);
      arm_eff[i] = trig_en[i] & ((state_q[i] == S_ARMED) |
                                 ((state_q[i] == S_INIT) & ~chain_up[i]));
      fire[i]    = arm_eff[i] & hit[i] & ~trig_cfg_wr[i] & (cnt_inc >= thr_eff);
    end
  end

  // Next-state and counter update for each trigger FSM.
  always_comb begin : fsm_p
    for (int i = 0; i < NUM_TRIG; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (trig_cfg_wr[i]) begin
        state_d[i] = S_INIT;
        cnt_d[i]   = '0;
      end else if (!trig_en[i]) begin
        state_d[i] = S_DISARMED;
        cnt_d[i]   = '0;
      end else if (arm_eff[i]) begin
        state_d[i] = S_ARMED;
        if (fire[i]) begin
          cnt_d[i] = '0;
          if (chain_up[i]) state_d[i] = S_DISARMED;
        end else if (hit[i]) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (!chain_up[i] || fire_up[i]) begin
        // Upstream fire arms this trigger from the next access onward.
        state_d[i] = S_ARMED;
      end
    end
  end

  // State, counters, registered fire pulse and sticky status (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TRIG; i++) begin
        state_q[i] <= S_INIT;
        cnt_q[i]   <= '0;
      end
      match_q  <= '0;
      status_q <= '0;
    end else begin
      for (int i = 0; i < NUM_TRIG; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      match_q  <= fire;
      status_q <= (status_q & ~trig_status_clr) | fire;
    end
  end

  assign lsu_trigger_match_dc4 = match_q;
  assign trig_status           = status_q;
  assign trig_armed            = arm_eff;

endmodule

// File: tb/tb_lsu_trigger_chain.sv
// Directed bench for lsu_trigger_chain (default parameters).
module tb_lsu_trigger_chain;
  localparam int NT = 4;
  localparam int DW = 32;
  localparam int CW = 8;

  logic             clk;
  logic             rst;
  logic [NT-1:0]    trig_en, trig_select, trig_load, trig_store, trig_napot, trig_chain;
  logic [NT*DW-1:0] trig_tdata2;
  logic [NT*CW-1:0] trig_thresh;
  logic [NT-1:0]    trig_cfg_wr, trig_status_clr;
  logic             lsu_valid_dc3, lsu_dma_dc3, lsu_kill_dc3, lsu_load_dc3, lsu_store_dc3;
  logic [1:0]       lsu_size_dc3;
  logic [DW-1:0]    lsu_addr_dc3, store_data_dc3, lsu_result_dc3;
  logic [NT-1:0]    lsu_trigger_match_dc4, trig_status, trig_armed;

  logic [NT-1:0]    exp_q[$];
  int               n_checks;
  int               n_pass;

  lsu_trigger_chain #(.NUM_TRIG(NT), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .trig_en(trig_en), .trig_select(trig_select), .trig_load(trig_load),
    .trig_store(trig_store), .trig_napot(trig_napot), .trig_chain(trig_chain),
    .trig_tdata2(trig_tdata2), .trig_thresh(trig_thresh),
    .trig_cfg_wr(trig_cfg_wr), .trig_status_clr(trig_status_clr),
    .lsu_valid_dc3(lsu_valid_dc3), .lsu_dma_dc3(lsu_dma_dc3), .lsu_kill_dc3(lsu_kill_dc3),
    .lsu_load_dc3(lsu_load_dc3), .lsu_store_dc3(lsu_store_dc3), .lsu_size_dc3(lsu_size_dc3),
    .lsu_addr_dc3(lsu_addr_dc3), .store_data_dc3(store_data_dc3),
    .lsu_result_dc3(lsu_result_dc3),
    .lsu_trigger_match_dc4(lsu_trigger_match_dc4), .trig_status(trig_status),
    .trig_armed(trig_armed)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lsu_valid_dc3  = 1'b0;
    lsu_dma_dc3    = 1'b0;
    lsu_kill_dc3   = 1'b0;
    lsu_load_dc3   = 1'b0;
    lsu_store_dc3  = 1'b0;
    lsu_size_dc3   = 2'd2;
    lsu_addr_dc3   = '0;
    store_data_dc3 = '0;
    lsu_result_dc3 = '0;
  endtask

  task automatic access(input logic ld, input logic st, input logic [1:0] sz,
                        input logic [DW-1:0] addr, input logic [DW-1:0] sdata,
                        input logic [DW-1:0] rdata);
    idle();
    lsu_valid_dc3  = 1'b1;
    lsu_load_dc3   = ld;
    lsu_store_dc3  = st;
    lsu_size_dc3   = sz;
    lsu_addr_dc3   = addr;
    store_data_dc3 = sdata;
    lsu_result_dc3 = rdata;
  endtask

  task automatic cfg(input int ch, input logic sel, input logic ld, input logic st,
                     input logic napot, input logic [DW-1:0] tdata, input logic [CW-1:0] thr);
    trig_select[ch]           = sel;
    trig_load[ch]             = ld;
    trig_store[ch]            = st;
    trig_napot[ch]            = napot;
    trig_tdata2[ch*DW +: DW]  = tdata;
    trig_thresh[ch*CW +: CW]  = thr;
  endtask

  task automatic cfg_write(input logic [NT-1:0] mask);
    idle();
    trig_cfg_wr = mask;
    tick();
    trig_cfg_wr = '0;
  endtask

  // Scoreboard: expected value queued, then compared against the observed output
  task automatic check(input string tag, input logic [NT-1:0] obs, input logic [NT-1:0] exp);
    logic [NT-1:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    n_checks++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, e);
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b1;
    trig_en     = 4'b0011;
    trig_select = '0;
    trig_load   = '0;
    trig_store  = '0;
    trig_napot  = '0;
    trig_chain  = '0;
    trig_tdata2 = '0;
    trig_thresh = '0;
    trig_cfg_wr = '0;
    trig_status_clr = '0;
    idle();
    #1;
    check("reset_armed", trig_armed, 4'b0011);
    check("reset_match", lsu_trigger_match_dc4, 4'b0000);
    check("reset_status", trig_status, 4'b0000);

    // 1: NAPOT address compare, thresh 1
    cfg(0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_00FF, 8'd1);
    @(negedge clk);
    rst = 1'b0;
    access(1'b1, 1'b0, 2'd2, 32'h8000_0010, '0, '0);
    tick();
    check("t1_napot_hit", lsu_trigger_match_dc4, 4'b0001);
    check("t1_status", trig_status, 4'b0001);
    access(1'b1, 1'b0, 2'd2, 32'h8000_0200, '0, '0);
    tick();
    check("t1_napot_miss", lsu_trigger_match_dc4, 4'b0000);
    idle();
    trig_status_clr = 4'b0001;
    tick();
    trig_status_clr = '0;
    check("t1_status_clr", trig_status, 4'b0000);

    // 2: store-data compare with threshold 3, then byte/half masking
    cfg(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 8'd3);
    cfg_write(4'b0001);
    access(1'b0, 1'b1, 2'd2, 32'h100, 32'h1234, '0);
    tick();
    check("t2_hit1", lsu_trigger_match_dc4, 4'b0000);
    tick();
    check("t2_hit2", lsu_trigger_match_dc4, 4'b0000);
    tick();
    check("t2_hit3_fire", lsu_trigger_match_dc4, 4'b0001);
    tick();
    check("t2_cnt_restart", lsu_trigger_match_dc4, 4'b0000);
    cfg(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0034, 8'd1);
    cfg_write(4'b0001);
    access(1'b0, 1'b1, 2'd0, 32'h100, 32'h0000_AB34, '0);
    tick();
    check("t2_byte_mask", lsu_trigger_match_dc4, 4'b0001);
    access(1'b0, 1'b1, 2'd1, 32'h100, 32'h0000_AB34, '0);
    tick();
    check("t2_half_nomatch", lsu_trigger_match_dc4, 4'b0000);
    trig_thresh[0 +: CW] = 8'd0;
    access(1'b0, 1'b1, 2'd0, 32'h100, 32'h0000_AB34, '0);
    tick();
    check("t2_thresh0", lsu_trigger_match_dc4, 4'b0001);

    // 3: chaining trig0 -> trig1
    cfg(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 8'd1);
    cfg(1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_01FF, 8'd1);
    trig_chain = 4'b0001;
    cfg_write(4'b0011);
    check("t3_armed_init", trig_armed, 4'b0001);
    access(1'b1, 1'b0, 2'd2, 32'h0000_0200, '0, '0);
    tick();
    check("t3_trig1_early", lsu_trigger_match_dc4, 4'b0000);
    access(1'b1, 1'b0, 2'd2, 32'h0000_0100, '0, '0);
    tick();
    check("t3_fire0_only", lsu_trigger_match_dc4, 4'b0001);
    check("t3_armed_after0", trig_armed, 4'b0011);
    access(1'b1, 1'b0, 2'd2, 32'h0000_0200, '0, '0);
    tick();
    check("t3_fire1", lsu_trigger_match_dc4, 4'b0010);
    check("t3_disarm1", trig_armed, 4'b0001);
    check("t3_status", trig_status, 4'b0011);

    // 4: kill/dma ignored; reset mid-count
    trig_chain = '0;
    trig_en    = 4'b0001;
    cfg(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 8'd3);
    cfg_write(4'b0001);
    access(1'b1, 1'b0, 2'd2, 32'h40, '0, '0);
    lsu_kill_dc3 = 1'b1;
    tick();
    check("t4_kill", lsu_trigger_match_dc4, 4'b0000);
    lsu_kill_dc3 = 1'b0;
    lsu_dma_dc3  = 1'b1;
    tick();
    check("t4_dma", lsu_trigger_match_dc4, 4'b0000);
    lsu_dma_dc3 = 1'b0;
    tick();
    check("t4_h1", lsu_trigger_match_dc4, 4'b0000);
    tick();
    check("t4_h2", lsu_trigger_match_dc4, 4'b0000);
    lsu_kill_dc3 = 1'b1;
    tick();
    check("t4_kill_mid", lsu_trigger_match_dc4, 4'b0000);
    lsu_kill_dc3 = 1'b0;
    tick();
    check("t4_h3_fire", lsu_trigger_match_dc4, 4'b0001);
    tick();
    tick();
    check("t4_cnt2", lsu_trigger_match_dc4, 4'b0000);
    idle();
    rst = 1'b1;
    #1;
    check("t4_rst_status", trig_status, 4'b0000);
    check("t4_rst_match", lsu_trigger_match_dc4, 4'b0000);
    check("t4_rst_armed", trig_armed, 4'b0001);
    @(negedge clk);
    rst = 1'b0;
    access(1'b1, 1'b0, 2'd2, 32'h40, '0, '0);
    tick();
    check("t4_post_h1", lsu_trigger_match_dc4, 4'b0000);
    tick();
    check("t4_post_h2", lsu_trigger_match_dc4, 4'b0000);
    tick();
    check("t4_post_h3", lsu_trigger_match_dc4, 4'b0001);

    // 5: status set beats clear; cfg_wr drops a same-cycle hit; disable
    trig_thresh[0 +: CW] = 8'd1;
    trig_status_clr = 4'b0001;
    tick();
    check("t5_set_wins", trig_status, 4'b0001);
    check("t5_fire", lsu_trigger_match_dc4, 4'b0001);
    idle();
    tick();
    trig_status_clr = '0;
    check("t5_clr", trig_status, 4'b0000);
    access(1'b1, 1'b0, 2'd2, 32'h40, '0, '0);
    trig_cfg_wr = 4'b0001;
    tick();
    trig_cfg_wr = '0;
    check("t5_cfgwr_drop", lsu_trigger_match_dc4, 4'b0000);
    tick();
    check("t5_after_cfgwr", lsu_trigger_match_dc4, 4'b0001);
    trig_en = 4'b0000;
    #1;
    check("t5_disabled_armed", trig_armed, 4'b0000);
    tick();
    check("t5_disabled_hit", lsu_trigger_match_dc4, 4'b0000);

    // 6: load-data compare
    trig_en = 4'b0001;
    cfg(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 8'd1);
    cfg_write(4'b0001);
    access(1'b1, 1'b0, 2'd2, 32'h0, '0, 32'hDEAD_BEEF);
    tick();
`ifdef LSU_TRIG_LOAD_DATA_EN
    check("t6_load_data", lsu_trigger_match_dc4, 4'b0001);
`else
    check("t6_load_data", lsu_trigger_match_dc4, 4'b0000);
`endif
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
